// File: rtl/stereo_frame_buffer_pkg.sv
// Shared definitions for the stereo frame buffer: state encoding, frame geometry, pixel position.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stereo_frame_buffer_pkg;

  localparam int unsigned WIDTH_DEF  = 250;
  localparam int unsigned HEIGHT_DEF = 125;
  localparam int unsigned ADDR_W_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READY   = 2'd3
  } cap_state_t;

  typedef struct packed {
    logic [9:0] vref;
    logic [9:0] href;
  } pix_pos_t;

  // Raster-order step: column wraps at last_col and carries into the row.
  function automatic pix_pos_t pos_advance(input pix_pos_t p, input logic [9:0] last_col);
    pix_pos_t n;
    n = p;
    if (p.href == last_col) begin
      n.href = '0;
      n.vref = p.vref + 10'd1;
    end else begin
      n.href = p.href + 10'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/stereo_frame_buffer_bram.sv
// One frame bank: 2^ADDR_W x 8 simple dual-port RAM, one write port, one registered read port.
// Latency: read data 1 clk after rd_addr; writes land on the same edge.
// Backpressure: none; contents are not reset.
module stereo_frame_buffer_bram #(
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_dat
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
    rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/stereo_frame_buffer.sv
// Captures one left and one right frame into two banks, then freezes them for disparity to read.
// Latency: image_data 1 clk after address/image_sel; buffer_ready 1 clk after the later last pixel.
// Backpressure: none; pixels outside a capture window are dropped, re-arm is gated by disp_idle.
module stereo_frame_buffer
  import stereo_frame_buffer_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned HEIGHT = HEIGHT_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       l_valid,
  input  logic       l_sof,
  input  logic [7:0] l_data,
  input  logic       r_valid,
  input  logic       r_sof,
  input  logic [7:0] r_data,
  input  logic [9:0] buffer_href,
  input  logic [9:0] buffer_vref,
  input  logic       image_sel,
  input  logic       disp_idle,
  output logic [7:0] image_data,
  output logic       buffer_ready,
  output logic [1:0] cap_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [9:0]        LAST_COL  = 10'(WIDTH - 1);

  cap_state_t        state;
  logic              idle_low_seen;
  logic              capture_en;
  logic [1:0]        cam_vld;
  logic [1:0]        cam_sof;
  logic [7:0]        cam_dat [2];
  logic [1:0]        started;
  logic [1:0]        done;
  logic [1:0]        wr_en;
  logic [1:0]        done_nxt;
  pix_pos_t          pos     [2];
  pix_pos_t          cur_pos [2];
  logic [ADDR_W-1:0] addr    [2];
  logic [ADDR_W-1:0] wr_addr [2];

  assign cam_vld    = {r_valid, l_valid};
  assign cam_sof    = {r_sof, l_sof};
  assign cam_dat[0] = l_data;
  assign cam_dat[1] = r_data;
  assign capture_en = (state == ST_ARM) || (state == ST_CAPTURE);
  assign cap_state  = state;

  // Index 0 = left camera, 1 = right camera. SOF always lands at (0,0) and restarts the frame.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      wr_en[c]   = capture_en && cam_vld[c] && (cam_sof[c] || (started[c] && !done[c]));
      wr_addr[c] = cam_sof[c] ? '0 : addr[c];
      cur_pos[c] = cam_sof[c] ? '0 : pos[c];
      if (wr_en[c] && (wr_addr[c] == LAST_ADDR)) begin
        done_nxt[c] = 1'b1;
      end else if (wr_en[c] && cam_sof[c]) begin
        done_nxt[c] = 1'b0;
      end else begin
        done_nxt[c] = done[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      buffer_ready  <= 1'b0;
      idle_low_seen <= 1'b0;
      started       <= '0;
      done          <= '0;
      for (int c = 0; c < 2; c++) begin
        pos[c]  <= '0;
        addr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (wr_en[c]) begin
          addr[c]    <= wr_addr[c] + ADDR_W'(1);
          pos[c]     <= pos_advance(cur_pos[c], LAST_COL);
          started[c] <= 1'b1;
          done[c]    <= done_nxt[c];
        end
      end

      case (state)
        ST_IDLE: begin
          if (enable) begin
            state   <= ST_ARM;
            started <= '0;
            done    <= '0;
          end
        end
        ST_ARM: begin
          if (|wr_en) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (&done_nxt) begin
            state         <= ST_READY;
            buffer_ready  <= 1'b1;
            idle_low_seen <= 1'b0;
          end
        end
        ST_READY: begin
          // Re-arm only on a low-then-high of disp_idle observed inside READY.
          if (!disp_idle) begin
            idle_low_seen <= 1'b1;
          end else if (idle_low_seen) begin
            state        <= ST_ARM;
            buffer_ready <= 1'b0;
            started      <= '0;
            done         <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_oor;
  logic              sel_q;
  logic              oor_q;
  logic [7:0]        l_rd_dat;
  logic [7:0]        r_rd_dat;

  assign rd_addr = ADDR_W'(buffer_vref) * ADDR_W'(WIDTH) + ADDR_W'(buffer_href);
  assign rd_oor  = (32'(buffer_href) >= WIDTH) || (32'(buffer_vref) >= HEIGHT);

  // oor_q resets high so image_data reads 0 out of reset without resetting the RAM outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= 1'b0;
      oor_q <= 1'b1;
    end else begin
      sel_q <= image_sel;
      oor_q <= rd_oor;
    end
  end

  assign image_data = oor_q ? 8'h00 : (sel_q ? r_rd_dat : l_rd_dat);

  stereo_frame_buffer_bram #(.ADDR_W(ADDR_W)) u_bram_l (
    .clk     (clk),
    .wr_en   (wr_en[0]),
    .wr_addr (wr_addr[0]),
    .wr_dat  (cam_dat[0]),
    .rd_addr (rd_addr),
    .rd_dat  (l_rd_dat)
  );

  stereo_frame_buffer_bram #(.ADDR_W(ADDR_W)) u_bram_r (
    .clk     (clk),
    .wr_en   (wr_en[1]),
    .wr_addr (wr_addr[1]),
    .wr_dat  (cam_dat[1]),
    .rd_addr (rd_addr),
    .rd_dat  (r_rd_dat)
  );

endmodule
